// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for a 5-stage RV32I pipeline.
// It drives the PC and pipeline-register enables and flushes, resolves load-use
// interlocks and branch/jump squashes, and waits on data memory through a
// req/ack handshake that has a timeout. It also keeps stall and flush counters.
// The enables and flushes are combinational so that they take effect with zero
// latency. The FSM state, the timeout counter, err and the counters are registered.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_wr_reg_n,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam bit          TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] wait_cnt_r;
  logic [15:0] wait_cnt_nxt_s;
  logic        err_r;
  logic        err_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic hold_s;       // memory stall is holding the whole pipeline this cycle
  logic active_s;     // normal hazard resolution applies this cycle
  logic lu_hit_s;     // raw load-use dependency between EX and ID
  logic redirect_s;   // redirect squash applied this cycle
  logic load_use_s;   // load-use interlock applied this cycle

  // Source-register match: x0 is never a real dependency.
  function automatic logic src_hit(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
    src_hit = uses && (rs == rd) && (rd != 5'd0);
  endfunction

  // Hazard decode and priority: ERROR > memory hold > redirect > load-use.
  always_comb begin
    lu_hit_s   = ex_is_load && !ex_wr_reg_n &&
                 (src_hit(id_uses_rs1, id_rs1, ex_rd) || src_hit(id_uses_rs2, id_rs2, ex_rd));
    hold_s     = ((state_r == ST_RUN) && mem_req && !dmem_ack) ||
                 ((state_r == ST_MEM_WAIT) && !dmem_ack);
    active_s   = (state_r != ST_ERROR) && !hold_s;
    redirect_s = active_s && ex_redirect;
    load_use_s = active_s && !ex_redirect && lu_hit_s;
  end

  // State, wait counter, error flag and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      wait_cnt_r  <= 16'd0;
      err_r       <= 1'b0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      err_r      <= err_nxt_s;
      if (!pc_en) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (redirect_s) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  // Next-state logic: enter MEM_WAIT on a stall, leave it on ack, time out to ERROR.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    err_nxt_s      = err_r;
    case (state_r)
      ST_RUN: begin
        if (mem_req && !dmem_ack) begin
          state_nxt_s    = ST_MEM_WAIT;
          wait_cnt_nxt_s = 16'd0;
        end else begin
          state_nxt_s    = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          state_nxt_s    = ST_RUN;
          wait_cnt_nxt_s = 16'd0;
        end else if (TO_EN && (wait_cnt_r == TO_LAST)) begin
          state_nxt_s    = ST_ERROR;
          err_nxt_s      = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 16'd1;
        end
      end
      ST_ERROR: begin
        state_nxt_s = ST_ERROR;
        err_nxt_s   = 1'b1;
      end
      default: begin
        state_nxt_s    = ST_RUN;
        wait_cnt_nxt_s = 16'd0;
      end
    endcase
  end

  // Output decode: zero-latency enables and flushes from the state, the inputs and rst_n.
  always_comb begin
    dmem_req     = 1'b0;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst_n) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (state_r == ST_ERROR) begin
      dmem_req = 1'b0;
    end else if (hold_s) begin
      dmem_req     = mem_req;
      mem_wb_flush = 1'b1;
    end else begin
      dmem_req  = mem_req;
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (redirect_s) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use_s) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
    end
  end

  assign err       = err_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl. The driver applies one directed vector per cycle
// and pushes the hand-computed outputs for that vector into a scoreboard. The
// monitor pops the scoreboard on each falling edge and compares the result.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic        ex_is_load = 1'b0, ex_wr_reg_n = 1'b1, ex_redirect = 1'b0;
  logic        mem_req = 1'b0, dmem_ack = 1'b0;
  logic        dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, err;
  logic [31:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_wr_reg_n(ex_wr_reg_n), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .dmem_ack(dmem_ack), .dmem_req(dmem_req), .pc_en(pc_en),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Control vector: {dmem_req, pc_en, en[if_id,id_ex,ex_mem,mem_wb], flush[if_id,id_ex,ex_mem,mem_wb]}
  localparam logic [9:0] V_RST   = 10'b00_0000_1111;
  localparam logic [9:0] V_IDLE  = 10'b01_1111_0000;
  localparam logic [9:0] V_LU    = 10'b00_0111_0100;
  localparam logic [9:0] V_RD    = 10'b01_1111_1100;
  localparam logic [9:0] V_STALL = 10'b10_0000_0001;
  localparam logic [9:0] V_ACK   = 10'b11_1111_0000;
  localparam logic [9:0] V_ACKRD = 10'b11_1111_1100;
  localparam logic [9:0] V_ERR   = 10'b00_0000_0000;

  typedef struct {
    string       name;
    logic [9:0]  ctl;
    logic        err;
    logic [31:0] s;
    logic [31:0] f;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  logic [9:0] act_ctl;
  assign act_ctl = {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  // Monitor: check one scoreboard entry per cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests = tests + 1;
      if (act_ctl !== e.ctl || err !== e.err || stall_cnt !== e.s || flush_cnt !== e.f) begin
        failed = failed + 1;
        $display("FAIL %s: got ctl=%b err=%b stall=%0d flush=%0d, expected ctl=%b err=%b stall=%0d flush=%0d",
                 e.name, act_ctl, err, stall_cnt, flush_cnt, e.ctl, e.err, e.s, e.f);
      end
    end
  end

  task automatic push(input string n, input logic [9:0] c, input logic e, input int s, input int f);
    exp_t x;
    x.name = n; x.ctl = c; x.err = e; x.s = 32'(s); x.f = 32'(f);
    sb.push_back(x);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic mr, input logic ack, input logic redir);
    mem_req = mr; dmem_ack = ack; ex_redirect = redir;
  endtask

  task automatic set_load(input logic ld, input logic [4:0] rd, input logic u1, input logic [4:0] r1,
                          input logic u2, input logic [4:0] r2);
    ex_is_load = ld; ex_wr_reg_n = !ld; ex_rd = rd;
    id_uses_rs1 = u1; id_rs1 = r1; id_uses_rs2 = u2; id_rs2 = r2;
  endtask

  initial begin
    // Reset held
    next_cycle(); push("reset_hold", V_RST, 1'b0, 0, 0);
    next_cycle(); rst_n = 1'b1; push("idle_after_reset", V_IDLE, 1'b0, 0, 0);
    // Load-use on rs1
    next_cycle(); set_load(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0); push("load_use_rs1", V_LU, 1'b0, 0, 0);
    next_cycle(); set_load(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0); push("after_load_use", V_IDLE, 1'b0, 1, 0);
    next_cycle(); set_load(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0); push("load_rd_x0", V_IDLE, 1'b0, 1, 0);
    next_cycle(); set_load(1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd7); push("load_use_rs2", V_LU, 1'b0, 1, 0);
    next_cycle(); set_load(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd7); push("rs2_not_used", V_IDLE, 1'b0, 2, 0);
    // Redirect coincident with load-use
    next_cycle(); set_load(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0); set_in(1'b0, 1'b0, 1'b1);
    push("redirect_over_lu", V_RD, 1'b0, 2, 0);
    next_cycle(); set_load(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0); set_in(1'b0, 1'b0, 1'b0);
    push("after_redirect", V_IDLE, 1'b0, 2, 1);
    // Memory wait: three cycles without ack, then ack
    next_cycle(); set_in(1'b1, 1'b0, 1'b0); push("mem_stall_1", V_STALL, 1'b0, 2, 1);
    next_cycle(); push("mem_stall_2", V_STALL, 1'b0, 3, 1);
    next_cycle(); push("mem_stall_3", V_STALL, 1'b0, 4, 1);
    next_cycle(); set_in(1'b1, 1'b1, 1'b0); push("mem_ack", V_ACK, 1'b0, 5, 1);
    next_cycle(); set_in(1'b0, 1'b0, 1'b0); push("after_mem", V_IDLE, 1'b0, 5, 1);
    // Memory stall with a pending redirect
    next_cycle(); set_in(1'b1, 1'b0, 1'b1); push("stall_redir_1", V_STALL, 1'b0, 5, 1);
    next_cycle(); push("stall_redir_2", V_STALL, 1'b0, 6, 1);
    next_cycle(); set_in(1'b1, 1'b1, 1'b1); push("ack_redir", V_ACKRD, 1'b0, 7, 1);
    next_cycle(); set_in(1'b0, 1'b0, 1'b0); push("after_ack_redir", V_IDLE, 1'b0, 7, 2);
    // Timeout with MEM_TIMEOUT=4
    next_cycle(); set_in(1'b1, 1'b0, 1'b0); push("to_stall_1", V_STALL, 1'b0, 7, 2);
    next_cycle(); push("to_stall_2", V_STALL, 1'b0, 8, 2);
    next_cycle(); push("to_stall_3", V_STALL, 1'b0, 9, 2);
    next_cycle(); push("to_stall_4", V_STALL, 1'b0, 10, 2);
    next_cycle(); push("to_stall_5", V_STALL, 1'b0, 11, 2);
    next_cycle(); push("error_entered", V_ERR, 1'b1, 12, 2);
    next_cycle(); set_in(1'b0, 1'b0, 1'b0); push("error_sticky", V_ERR, 1'b1, 13, 2);
    next_cycle(); set_in(1'b0, 1'b0, 1'b1); push("error_no_flush", V_ERR, 1'b1, 14, 2);
    // Reset clears the error
    next_cycle(); rst_n = 1'b0; set_in(1'b0, 1'b0, 1'b0); push("reset_clears", V_RST, 1'b0, 0, 0);
    next_cycle(); rst_n = 1'b1; set_in(1'b1, 1'b0, 1'b0); push("rst_mw_stall", V_STALL, 1'b0, 0, 0);
    next_cycle(); push("rst_mw_wait", V_STALL, 1'b0, 1, 0);
    // Asynchronous reset pulse in the middle of MEM_WAIT, with a stale ack
    next_cycle(); rst_n = 1'b0; set_in(1'b1, 1'b1, 1'b0); push("async_reset_pulse", V_RST, 1'b0, 0, 0);
    #5; rst_n = 1'b1;
    next_cycle(); set_in(1'b0, 1'b0, 1'b0); push("run_after_pulse", V_IDLE, 1'b0, 0, 0);
    next_cycle(); set_in(1'b1, 1'b1, 1'b0); push("run_ack_no_stall", V_ACK, 1'b0, 0, 0);
    next_cycle(); set_in(1'b0, 1'b0, 1'b0);
    // Drain the scoreboard with a bound on the number of cycles
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      tests = tests + 1;
      failed = failed + 1;
      $display("FAIL drain: %0d entries left unchecked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32I pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It handles load-use interlocks, branch/jump redirect squashing, and multi-cycle data-memory waits through a req/ack handshake with a timeout. It also keeps performance counters for stall and flush cycles.

Parameters:
MEM_TIMEOUT, 16, max MEM_WAIT cycles without dmem_ack before entering ERROR; 0 disables the timeout.
CNT_W, 32, width of performance counters (wrap-around).

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
id_rs1  input  5  rs1 of instruction in ID
id_rs2  input  5  rs2 of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_rd  input  5  destination of instruction in EX
ex_is_load  input  1  EX instruction is a load
ex_wr_reg_n  input  1  EX instruction register write, active-low
ex_redirect  input  1  EX resolved taken branch or jump (PC redirect)
mem_req  input  1  MEM instruction accesses data memory
dmem_ack  input  1  data memory completes access this cycle
dmem_req  output  1  request to data memory
pc_en  output  1  PC register load enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  pipeline register load enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1 each  load bubble (wr_reg_n=1, jump=0); overrides en
err  output  1  sticky memory-timeout error
stall_cnt  output  CNT_W  cycles with pc_en=0
flush_cnt  output  CNT_W  cycles with ex_redirect squash applied

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Registers: state, wait_cnt (16 bit), err, stall_cnt, flush_cnt.
- Reset (async): state=RUN, wait_cnt=0, err=0, both counters=0. While rst_n=0: all en=0, all flush=1, dmem_req=0.
- All enable/flush outputs are combinational in the state and current inputs; they have zero latency.
- Default in RUN: all en=1, all flush=0, pc_en=1.
- dmem_req = mem_req when state is not ERROR; otherwise 0.
- mem_stall (RUN) = mem_req && !dmem_ack:
  - pc_en and all four en=0.
  - mem_wb_flush=1, so no duplicate writeback.
  - Next state is MEM_WAIT with wait_cnt=0.
- MEM_WAIT:
  - Outputs are the same as mem_stall.
  - If dmem_ack=1: all en=1, mem_wb_flush=0, next state RUN.
  - Otherwise wait_cnt increments. If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT-1, next state is ERROR and err is set.
- Load-use (RUN, no mem_stall) = ex_is_load && !ex_wr_reg_n && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)):
  - pc_en=0, if_id_en=0.
  - id_ex_flush=1.
  - ex_mem_en=1, mem_wb_en=1.
- Redirect (RUN, no mem_stall, ex_redirect=1):
  - if_id_flush=1, id_ex_flush=1, pc_en=1.
  - Redirect has priority over load-use, because the dependent instruction is squashed.
  - flush_cnt increments.
- Priority order: ERROR > mem_stall/MEM_WAIT > redirect > load-use > normal.
- Redirect coincident with mem stall: the stall wins and the redirect is not latched. EX is frozen, so ex_redirect re-presents and is applied on the release cycle.
- ERROR:
  - All en=0, pc_en=0, all flush=0, dmem_req=0.
  - err stays 1 until reset.
  - stall_cnt keeps counting.
- stall_cnt increments every cycle pc_en=0 outside reset. Both counters wrap modulo 2^CNT_W.
- Reset asserted mid-MEM_WAIT returns to RUN immediately, with no stale ack effect.

Test Plan:
- Load-use: EX lw x5 (ex_is_load=1, ex_wr_reg_n=0, ex_rd=5), ID add using rs1=5 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. stall_cnt goes 0→1. With ex_rd=0 there is no stall.
- Redirect + load-use same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1. flush_cnt=1, stall_cnt=0.
- Memory wait: mem_req=1, dmem_ack low for 3 cycles then high -> pc_en=0 and mem_wb_flush=1 for 3 cycles, dmem_req held 4 cycles. RUN on the ack cycle with all en=1. stall_cnt=3.
- Timeout, MEM_TIMEOUT=4, ack never arrives -> err=1 on the 5th edge after the first stall cycle. dmem_req=0 thereafter, and err persists until rst_n low.
- Mem stall with ex_redirect=1 for 2 cycles, then ack -> no flush during the stall. Squash is applied on the ack cycle, flush_cnt=1.
- Async reset pulse mid-MEM_WAIT, between clock edges -> all flush=1 and en=0 immediately. After release: RUN, counters 0, err 0.
